// File: rtl/uart_cmd_frame_tx.sv
// uart_cmd_frame_tx: transmit side of the UART command link.
// Builds the fixed 8-byte command frame
//   FRAME_HEAD0, FRAME_HEAD1, time[31:24], time[23:16], time[15:8], time[7:0], ctrl, FRAME_TAIL
// and sends it as 8N1, LSB first. Bytes go back to back; a frame is exactly 80 bit periods.
// Ports:
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   send_go    - start request, only honoured while idle
//   ctrl_set   - control byte, captured on accept
//   time_set   - 32-bit time value, captured on accept
//   baud_set   - baud code (0:9600 1:19200 2:38400 3:57600 4..7:115200), captured on accept
//   uart_tx    - registered serial line, idles high
//   busy       - high from the cycle after accept until the last stop bit ends
//   frame_done - one-cycle pulse in the cycle after the last stop bit
module uart_cmd_frame_tx #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter logic [7:0]  FRAME_HEAD0 = 8'h55,
  parameter logic [7:0]  FRAME_HEAD1 = 8'hA5,
  parameter logic [7:0]  FRAME_TAIL  = 8'hF0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        send_go,
  input  logic [7:0]  ctrl_set,
  input  logic [31:0] time_set,
  input  logic [2:0]  baud_set,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done
);

  // Cycles per bit; truncating division gives 5208/2604/1302/868/434 at 50 MHz.
  localparam logic [12:0] Div9600   = 13'(CLK_FREQ / 9600);
  localparam logic [12:0] Div19200  = 13'(CLK_FREQ / 19200);
  localparam logic [12:0] Div38400  = 13'(CLK_FREQ / 38400);
  localparam logic [12:0] Div57600  = 13'(CLK_FREQ / 57600);
  localparam logic [12:0] Div115200 = 13'(CLK_FREQ / 115200);

  typedef enum logic [1:0] {StIdle, StTxBit, StNextByte} state_e;

  state_e      r_state, w_state_d;
  logic [7:0]  r_ctrl;
  logic [31:0] r_time;
  logic [2:0]  r_baud;
  logic [12:0] r_baud_cnt;
  logic [3:0]  r_bit_idx;
  logic [2:0]  r_byte_idx;
  logic [9:0]  r_shift;  // {stop, d7..d0, start}; bit 0 is on the line

  logic [12:0] w_div;
  logic        w_bit_end;
  logic        w_stop_end;
  logic        w_last_byte;
  logic [2:0]  w_next_idx;
  logic [7:0]  w_next_byte;

  always_comb begin
    case (r_baud)
      3'd0:    w_div = Div9600;
      3'd1:    w_div = Div19200;
      3'd2:    w_div = Div38400;
      3'd3:    w_div = Div57600;
      default: w_div = Div115200;
    endcase
  end

  assign w_bit_end   = (r_baud_cnt == w_div - 13'd1);
  assign w_stop_end  = w_bit_end && (r_bit_idx == 4'd9);
  assign w_last_byte = (r_byte_idx == 3'd7);
  assign w_next_idx  = r_byte_idx + 3'd1;

  // Byte that follows the current one, ready before the current stop bit ends.
  always_comb begin
    unique case (w_next_idx)
      3'd0: w_next_byte = FRAME_HEAD0;
      3'd1: w_next_byte = FRAME_HEAD1;
      3'd2: w_next_byte = r_time[31:24];
      3'd3: w_next_byte = r_time[23:16];
      3'd4: w_next_byte = r_time[15:8];
      3'd5: w_next_byte = r_time[7:0];
      3'd6: w_next_byte = r_ctrl;
      3'd7: w_next_byte = FRAME_TAIL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (send_go) w_state_d = StTxBit;
      end
      StTxBit: begin
        busy = 1'b1;
        if (w_stop_end) w_state_d = StNextByte;
      end
      StNextByte: begin
        if (w_last_byte) begin
          frame_done = 1'b1;
          w_state_d  = StIdle;
        end else begin
          // Line already carries the next start bit here.
          busy      = 1'b1;
          w_state_d = StTxBit;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl     <= '0;
      r_time     <= '0;
      r_baud     <= '0;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '1;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (send_go) begin
            r_ctrl     <= ctrl_set;
            r_time     <= time_set;
            r_baud     <= baud_set;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= {1'b1, FRAME_HEAD0, 1'b0};
          end
        end
        StTxBit: begin
          if (!w_bit_end) begin
            r_baud_cnt <= r_baud_cnt + 13'd1;
          end else if (r_bit_idx != 4'd9) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= r_bit_idx + 4'd1;
            r_shift    <= {1'b1, r_shift[9:1]};
          end else begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            // Next start bit goes out during StNextByte so the boundary costs no line time.
            r_shift    <= w_last_byte ? 10'h3FF : {1'b1, w_next_byte, 1'b0};
          end
        end
        StNextByte: begin
          if (!w_last_byte) begin
            r_byte_idx <= w_next_idx;
            // StNextByte was cycle 0 of the start bit.
            r_baud_cnt <= 13'd1;
          end else begin
            r_byte_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign uart_tx = r_shift[0];

endmodule
